heartbeat_gen: RTL
==================

Name: heartbeat_gen

Overview:
Multi-channel programmable heartbeat generator. It replaces the fixed single-output heartbeat with CHANNELS independent counters. Each channel has its own period, duty and mode, and configuration updates are glitch-free because they are shadowed and applied only at the frame boundary. It sits beside the clock/reset logic and drives status LEDs, liveness pulses and PWM indicators. A global sync input phase-aligns all channels.

Parameters:
N, 8, counter/period/duty width in bits (N >= 2)
CHANNELS, 4, number of independent channels (1..16)
CHW, 4, width of the channel-select field (must satisfy 2^CHW >= CHANNELS)

Ports:
clk  in  1  single clock; all state changes on the rising edge
nreset  in  1  asynchronous active-low reset
en  in  CHANNELS  per-channel enable, level sensitive
sync  in  1  synchronous restart of all channels, one-cycle strobe
cfg_we  in  1  config write strobe
cfg_ch  in  CHW  target channel of the write
cfg_mode  in  2  mode: 00 off, 01 toggle, 10 pulse, 11 pwm
cfg_period  in  N  frame length minus 1 (frame = period+1 cycles)
cfg_duty  in  N  pwm high-cycle count
out  out  CHANNELS  heartbeat outputs, registered
wrap  out  CHANNELS  one-cycle strobe at each frame end, registered
pending  out  CHANNELS  shadow config waiting to be applied
cfg_err  out  1  one-cycle strobe when cfg_ch >= CHANNELS

Behaviour:
- Async reset, applied while nreset=0, for every channel:
  - cnt=0, out=0, wrap=0, pending=0, cfg_err=0.
  - Active config: mode=01, period=2^N-1, duty=2^(N-1).
- Terminal count: tc[i] = en[i] & (cnt[i]==period[i]).
- en[i]=1, no tc: cnt <= cnt+1, wrap <= 0.
- en[i]=1, tc: cnt <= 0, wrap <= 1 (one cycle, registered, so it appears the cycle after cnt==period).
- en[i]=0:
  - cnt, out and wrap are held at 0.
  - A pending config is applied on the next edge.
  - When en rises, cnt is 0 on that edge and counts from the following edge.
- Mode 00 (off): counter and wrap run normally; out forced 0.
- Mode 01 (toggle): out flips on each tc.
  - First flip comes period+1 cycles after enable.
  - out is a square wave of period 2*(period+1).
- Mode 10 (pulse): out <= tc, so out is high exactly one cycle per frame, coincident with wrap.
- Mode 11 (pwm):
  - out <= (cnt_next < duty), where cnt_next is the value cnt takes on that edge.
  - Result: out is high for the first min(duty, period+1) cycles of each frame.
  - duty=0 gives constant 0; duty > period gives constant 1.
- period=0:
  - tc every enabled cycle.
  - Toggle gives out flipping every cycle; pulse gives out constant 1.
  - pwm gives out = (duty != 0).
- Config write, when cfg_we=1 and cfg_ch < CHANNELS:
  - The shadow of cfg_ch is loaded and pending[cfg_ch] <= 1.
  - A repeated write before apply overwrites the shadow; the last write wins.
- Config write with cfg_ch >= CHANNELS: write ignored, cfg_err <= 1 for one cycle, no state change.
- Apply:
  - The shadow is copied to the active config, and pending is cleared, on the edge where tc[i]=1, or sync=1, or en[i]=0.
  - A write in the same cycle as an apply event bypasses the shadow: the cfg_* values become active on that edge and pending stays 0.
- Mode change on apply:
  - out is recomputed for the new mode from cnt=0.
  - Toggle restarts at out=0, so there is no carried-over phase.
- sync=1:
  - Every channel cnt <= 0, out <= 0, and pending configs are applied.
  - wrap <= 0 even if tc coincides; sync has priority over tc.
  - Enabled pwm channels with duty > 0 re-assert out on the following edge.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); shadow contents are lost.
- Counter arithmetic is N-bit unsigned and never exceeds period.
- If period is lowered at apply, cnt is 0 at that moment, so no overflow past period occurs.

Test Plan:
1. N=4, CHANNELS=2, reset, then en=2'b01 with default config -> out[0] toggles every 16 cycles, wrap[0] pulses every 16 cycles; out[1], wrap[1] and pending remain 0.
2. Write ch1 mode=10, period=3, then en[1]=1 -> out[1]=wrap[1]=1 for one cycle every 4 cycles; first pulse on the 4th edge after enable.
3. Write ch0 mode=11, period=9, duty=3 mid-frame -> pending[0]=1 until the next wrap[0]; then out[0] is high 3 cycles and low 7 cycles per frame; duty=12 -> out[0] constant 1.
4. Two writes to ch0 before its wrap (period=5, then period=7) -> only period=7 is applied, and the frame is 8 cycles; cfg_we with cfg_ch=3 -> cfg_err one cycle, no channel changes.
5. Channels mid-frame at different phases, assert sync one cycle -> all cnt=0 and out=0 next cycle, pending cleared; identical configs then produce identical out/wrap waveforms.
6. Drop nreset mid-frame with pending[1]=1 -> out, wrap and pending go to 0 without waiting for a clock; after release the default config is active and the pending write is discarded.

Source files
------------

// File: rtl/heartbeat_gen.sv
// Multi-channel programmable heartbeat generator: per-channel counters with shadowed
// mode/period/duty that only take effect at a frame boundary, sync restart or while disabled.
module heartbeat_gen #(
  parameter int N        = 8,
  parameter int CHANNELS = 4,
  parameter int CHW      = 4
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                cfg_we,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [N-1:0]        cfg_period,
  input  logic [N-1:0]        cfg_duty,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] wrap,
  output logic [CHANNELS-1:0] pending,
  output logic                cfg_err
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_PULSE  = 2'b10,
    MODE_PWM    = 2'b11
  } mode_t;

  localparam logic [N-1:0] DEF_PERIOD = '1;
  localparam logic [N-1:0] DEF_DUTY   = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0]        r_cnt       [CHANNELS];
  logic [N-1:0]        r_period    [CHANNELS];
  logic [N-1:0]        r_duty      [CHANNELS];
  mode_t               r_mode      [CHANNELS];
  logic [N-1:0]        r_sh_period [CHANNELS];
  logic [N-1:0]        r_sh_duty   [CHANNELS];
  mode_t               r_sh_mode   [CHANNELS];
  logic [CHANNELS-1:0] r_out;
  logic [CHANNELS-1:0] r_wrap;
  logic [CHANNELS-1:0] r_pending;
  logic                r_cfg_err;

  logic [N-1:0]        w_cnt       [CHANNELS];
  logic [N-1:0]        w_period    [CHANNELS];
  logic [N-1:0]        w_duty      [CHANNELS];
  mode_t               w_mode      [CHANNELS];
  logic [N-1:0]        w_sh_period [CHANNELS];
  logic [N-1:0]        w_sh_duty   [CHANNELS];
  mode_t               w_sh_mode   [CHANNELS];
  logic [CHANNELS-1:0] w_out;
  logic [CHANNELS-1:0] w_wrap;
  logic [CHANNELS-1:0] w_pending;
  logic [CHANNELS-1:0] w_tc;
  logic [CHANNELS-1:0] w_we;
  logic [CHANNELS-1:0] w_apply;
  logic [CHANNELS-1:0] w_load;
  logic                w_cfg_err;

  always_comb begin
    w_cfg_err = cfg_we && (32'(cfg_ch) >= CHANNELS);
    for (int i = 0; i < CHANNELS; i++) begin
      w_tc[i]        = en[i] && (r_cnt[i] == r_period[i]);
      w_we[i]        = cfg_we && !w_cfg_err && (32'(cfg_ch) == i);
      w_apply[i]     = w_tc[i] || sync || !en[i];
      w_load[i]      = w_apply[i] && (r_pending[i] || w_we[i]);
      w_mode[i]      = r_mode[i];
      w_period[i]    = r_period[i];
      w_duty[i]      = r_duty[i];
      w_sh_mode[i]   = r_sh_mode[i];
      w_sh_period[i] = r_sh_period[i];
      w_sh_duty[i]   = r_sh_duty[i];
      w_pending[i]   = r_pending[i];

      // A write landing on an apply edge skips the shadow and goes live directly.
      if (w_apply[i]) begin
        w_pending[i] = 1'b0;
        if (w_we[i]) begin
          w_mode[i]   = mode_t'(cfg_mode);
          w_period[i] = cfg_period;
          w_duty[i]   = cfg_duty;
        end else if (r_pending[i]) begin
          w_mode[i]   = r_sh_mode[i];
          w_period[i] = r_sh_period[i];
          w_duty[i]   = r_sh_duty[i];
        end
      end else if (w_we[i]) begin
        w_sh_mode[i]   = mode_t'(cfg_mode);
        w_sh_period[i] = cfg_period;
        w_sh_duty[i]   = cfg_duty;
        w_pending[i]   = 1'b1;
      end

      w_cnt[i]  = w_apply[i] ? '0 : r_cnt[i] + N'(1);
      w_wrap[i] = w_tc[i] && !sync;
      w_out[i]  = 1'b0;
      if (en[i] && !sync) begin
        case (w_mode[i])
          MODE_OFF:    w_out[i] = 1'b0;
          MODE_TOGGLE: w_out[i] = w_load[i] ? 1'b0 : (r_out[i] ^ w_tc[i]);
          MODE_PULSE:  w_out[i] = w_tc[i];
          MODE_PWM:    w_out[i] = (w_cnt[i] < w_duty[i]);
          default:     w_out[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i]       <= '0;
        r_mode[i]      <= MODE_TOGGLE;
        r_period[i]    <= DEF_PERIOD;
        r_duty[i]      <= DEF_DUTY;
        r_sh_mode[i]   <= MODE_TOGGLE;
        r_sh_period[i] <= DEF_PERIOD;
        r_sh_duty[i]   <= DEF_DUTY;
      end
      r_out     <= '0;
      r_wrap    <= '0;
      r_pending <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i]       <= w_cnt[i];
        r_mode[i]      <= w_mode[i];
        r_period[i]    <= w_period[i];
        r_duty[i]      <= w_duty[i];
        r_sh_mode[i]   <= w_sh_mode[i];
        r_sh_period[i] <= w_sh_period[i];
        r_sh_duty[i]   <= w_sh_duty[i];
      end
      r_out     <= w_out;
      r_wrap    <= w_wrap;
      r_pending <= w_pending;
      r_cfg_err <= w_cfg_err;
    end
  end

  assign out     = r_out;
  assign wrap    = r_wrap;
  assign pending = r_pending;
  assign cfg_err = r_cfg_err;

endmodule
